// File: rtl/ecg_buf_pkg.sv
// Shared definitions for the ping-pong ECG sample buffer (writer and pair reader).
package ecg_buf_pkg;

    localparam int DATA_W_DEF    = 12;
    localparam int ADDR_W_DEF    = 12;
    localparam int FRAME_LEN_DEF = 2048;

    // Address MSB selects the bank; the reader decodes the same bit.
    localparam int BANK_BIT = ADDR_W_DEF - 1;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        PAD      = 2'd1,
        WAIT_REL = 2'd2
    } wr_state_e;

    function automatic int bank_bit_pos(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// Flags any level change on a toggle input relative to the previous cycle.
module toggle_edge_det (
    input  logic clk,
    input  logic i_tog,
    output logic o_edge
);

    logic r_tog_q;

    // Sampled every cycle, reset included, so a toggle during reset is not seen as a release.
    always_ff @(posedge clk) begin
        r_tog_q <= i_tog;
    end

    assign o_edge = i_tog ^ r_tog_q;

endmodule

// File: rtl/pingpong_sample_writer.sv
// Write side of the ping-pong sample buffer: fills one BRAM bank per frame,
// pads odd-length flushed frames to an even count and stalls until the reader frees a bank.
module pingpong_sample_writer
    import ecg_buf_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              flush,
    input  logic              rd_switch,
    output logic              wea,
    output logic [ADDR_W-1:0] addr_w,
    output logic [DATA_W-1:0] dina,
    output logic [ADDR_W-1:0] load,
    output logic              frame_done,
    output logic              wr_bank
);

    localparam int                BANK     = bank_bit_pos(ADDR_W);
    localparam int                IDX_W    = ADDR_W - 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

    wr_state_e         r_state;
    wr_state_e         w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [1:0]        r_full;
    logic [1:0]        w_full_rel;
    logic [1:0]        w_full_next;
    logic              r_wr_bank;
    logic              r_s_ready;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addr_w;
    logic [DATA_W-1:0] r_dina;
    logic [ADDR_W-1:0] r_load;
    logic [ADDR_W-1:0] w_load_next;
    logic              r_frame_done;
    logic              w_close;
    logic              w_pad;
    logic              w_xfer;
    logic              w_rel;

    toggle_edge_det u_rel_det (
        .clk    (clk),
        .i_tog  (rd_switch),
        .o_edge (w_rel)
    );

    assign w_xfer = s_valid && r_s_ready;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_load_next  = r_load;
        w_close      = 1'b0;
        w_pad        = 1'b0;
        w_full_rel   = r_full;

        // While stalled both banks are full and the reader is freeing the one we want next.
        if (w_rel) begin
            if (r_state == WAIT_REL) begin
                w_full_rel[r_wr_bank] = 1'b0;
            end else begin
                w_full_rel[~r_wr_bank] = 1'b0;
            end
        end

        case (r_state)
            FILL: begin
                if (w_xfer) begin
                    w_idx_next = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_close     = 1'b1;
                        w_load_next = ADDR_W'(r_idx);
                    end else if (flush) begin
                        if (!r_idx[0]) begin
                            w_state_next = PAD;
                        end else begin
                            w_close     = 1'b1;
                            w_load_next = ADDR_W'(r_idx);
                        end
                    end
                end else if (flush && (r_idx != '0)) begin
                    if (r_idx[0]) begin
                        w_state_next = PAD;
                    end else begin
                        w_close     = 1'b1;
                        w_load_next = ADDR_W'(r_idx - 1'b1);
                    end
                end
            end
            PAD: begin
                w_pad       = 1'b1;
                w_close     = 1'b1;
                w_load_next = ADDR_W'(r_idx);
            end
            WAIT_REL: begin
                if (!w_full_rel[r_wr_bank]) begin
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase

        w_full_next = w_full_rel;
        if (w_close) begin
            w_full_next[r_wr_bank] = 1'b1;
            w_idx_next             = '0;
            w_state_next           = w_full_rel[~r_wr_bank] ? WAIT_REL : FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_full       <= '0;
            r_wr_bank    <= 1'b0;
            r_s_ready    <= 1'b0;
            r_wea        <= 1'b0;
            r_addr_w     <= '0;
            r_dina       <= '0;
            r_load       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_full       <= w_full_next;
            // One dead cycle after every close keeps handover and the next frame apart.
            r_s_ready    <= (w_state_next == FILL) && !w_close;
            r_frame_done <= w_close;
            r_load       <= w_load_next;
            r_wea        <= w_xfer || w_pad;
            if (w_close) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_xfer || w_pad) begin
                r_addr_w[BANK]      <= r_wr_bank;
                r_addr_w[BANK-1:0]  <= r_idx;
                r_dina              <= w_pad ? '0 : s_data;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign wea        = r_wea;
    assign addr_w     = r_addr_w;
    assign dina       = r_dina;
    assign load       = r_load;
    assign frame_done = r_frame_done;
    assign wr_bank    = r_wr_bank;

endmodule

// File: tb/tb_pingpong_sample_writer.sv
// Randomized-data bench for pingpong_sample_writer with an 8-sample frame and a
// queue-based reference model of writes and frame handovers.
module tb_pingpong_sample_writer;

    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        flush;
    logic        rd_switch;
    logic        wea;
    logic [11:0] addr_w;
    logic [11:0] dina;
    logic [11:0] load;
    logic        frame_done;
    logic        wr_bank;

    int checks   = 0;
    int failures = 0;

    logic [23:0] mon_wr[$];
    logic [23:0] exp_wr[$];
    logic [12:0] mon_fd[$];
    logic [12:0] exp_fd[$];

    int   m_idx;
    logic m_bank;

    pingpong_sample_writer #(
        .DATA_W    (12),
        .ADDR_W    (12),
        .FRAME_LEN (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .flush      (flush),
        .rd_switch  (rd_switch),
        .wea        (wea),
        .addr_w     (addr_w),
        .dina       (dina),
        .load       (load),
        .frame_done (frame_done),
        .wr_bank    (wr_bank)
    );

    always #5 clk = ~clk;

    // Monitor plus reference model: frames are counted in accepted samples, flushes close
    // them early (padding odd counts with a zero), and each close flips the bank.
    initial begin
        m_idx  = 0;
        m_bank = 1'b0;
        forever begin
            @(negedge clk);
            if (wea === 1'b1) mon_wr.push_back({addr_w, dina});
            if (frame_done === 1'b1) mon_fd.push_back({wr_bank, load});
            if (rst) begin
                m_idx  = 0;
                m_bank = 1'b0;
            end else begin
                if (s_valid && s_ready) begin
                    exp_wr.push_back({m_bank, 11'(m_idx), s_data});
                    m_idx++;
                    if (m_idx == FL) begin
                        exp_fd.push_back({~m_bank, 12'(FL - 1)});
                        m_bank = ~m_bank;
                        m_idx  = 0;
                    end
                end
                if (flush && m_idx != 0) begin
                    if (m_idx % 2 == 1) begin
                        exp_wr.push_back({m_bank, 11'(m_idx), 12'h000});
                        m_idx++;
                    end
                    exp_fd.push_back({~m_bank, 12'(m_idx - 1)});
                    m_bank = ~m_bank;
                    m_idx  = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_wr.delete();
        exp_wr.delete();
        mon_fd.delete();
        exp_fd.delete();
    endtask

    task automatic send_n(input int n, output bit ok);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 200) begin
            s_valid = 1'b1;
            s_data  = 12'($urandom);
            if (s_ready) sent++;
            @(posedge clk);
            #1 cyc++;
        end
        s_valid = 1'b0;
        ok = (sent == n);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wea !== 1'b0) begin failures++; $display("FAIL reset_wea: got %b want 0", wea); end
        checks++; if (addr_w !== 12'h000) begin failures++; $display("FAIL reset_addr: got %h want 000", addr_w); end
        checks++; if (dina !== 12'h000) begin failures++; $display("FAIL reset_dina: got %h want 000", dina); end
        checks++; if (load !== 12'h000) begin failures++; $display("FAIL reset_load: got %h want 000", load); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        checks++; if (wr_bank !== 1'b0) begin failures++; $display("FAIL reset_bank: got %b want 0", wr_bank); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", s_ready); end
        $display("test_reset done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_continuous();
        int fd_seen = 0;
        int tog     = 0;
        int low_run = 0;
        int max_low = 0;
        int cyc     = 0;
        do_reset();
        while (fd_seen < 2 && cyc < 80) begin
            s_valid = 1'b1;
            s_data  = 12'($urandom);
            if (s_ready) low_run = 0;
            else begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end
            @(posedge clk);
            #1 cyc++;
            if (frame_done) begin
                fd_seen++;
                tog = 2;
            end else if (tog > 0) begin
                tog--;
                if (tog == 0) rd_switch = ~rd_switch;
            end
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fd_seen != 2) begin failures++; $display("FAIL cont_frames: got %0d want 2", fd_seen); end
        checks++; if (max_low > 1) begin failures++; $display("FAIL cont_ready_gap: got %0d want <=1", max_low); end
        checks++;
        if (mon_wr.size() != 2 * FL) begin
            failures++; $display("FAIL cont_wr_count: got %0d want %0d", mon_wr.size(), 2 * FL);
        end else begin
            for (int i = 0; i < 2 * FL; i++) begin
                checks++;
                if (mon_wr[i][23:12] !== ((i < FL) ? 12'(i) : 12'(12'h800 + i - FL))) begin
                    failures++; $display("FAIL cont_addr[%0d]: got %h want %h", i, mon_wr[i][23:12],
                                         (i < FL) ? 12'(i) : 12'(12'h800 + i - FL));
                end
            end
        end
        checks++;
        if (mon_fd.size() != exp_fd.size()) begin
            failures++; $display("FAIL cont_fd_count: got %0d want %0d", mon_fd.size(), exp_fd.size());
        end else begin
            foreach (exp_fd[i]) begin
                checks++;
                if (mon_fd[i] !== exp_fd[i]) begin
                    failures++; $display("FAIL cont_fd[%0d]: got bank=%b load=%0d want bank=%b load=%0d",
                                         i, mon_fd[i][12], mon_fd[i][11:0], exp_fd[i][12], exp_fd[i][11:0]);
                end
            end
        end
        checks++;
        if (mon_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL cont_model_count: got %0d want %0d", mon_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (mon_wr[i] !== exp_wr[i]) begin
                    failures++; $display("FAIL cont_wr[%0d]: got %h want %h", i, mon_wr[i], exp_wr[i]);
                end
            end
        end
        $display("test_continuous done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_no_release();
        int fd_seen = 0;
        int cyc     = 0;
        int rdy_cnt = 0;
        int wr_cnt  = 0;
        bit ok;
        do_reset();
        while (fd_seen < 2 && cyc < 80) begin
            s_valid = 1'b1;
            s_data  = 12'($urandom);
            @(posedge clk);
            #1 cyc++;
            if (frame_done) fd_seen++;
        end
        checks++; if (fd_seen != 2) begin failures++; $display("FAIL norel_frames: got %0d want 2", fd_seen); end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (s_ready) rdy_cnt++;
            if (wea) wr_cnt++;
        end
        checks++; if (rdy_cnt != 0) begin failures++; $display("FAIL norel_stall_ready: got %0d want 0", rdy_cnt); end
        checks++; if (wr_cnt != 0) begin failures++; $display("FAIL norel_stall_writes: got %0d want 0", wr_cnt); end
        checks++; if (wr_bank !== 1'b0) begin failures++; $display("FAIL norel_bank: got %b want 0", wr_bank); end
        rd_switch = ~rd_switch;
        send_n(1, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL norel_resume: got timeout want accepted sample"); end
        checks++;
        if (mon_wr.size() != 2 * FL + 1) begin
            failures++; $display("FAIL norel_wr_count: got %0d want %0d", mon_wr.size(), 2 * FL + 1);
        end else if (mon_wr[2 * FL][23:12] !== 12'h000) begin
            failures++; $display("FAIL norel_resume_addr: got %h want 000", mon_wr[2 * FL][23:12]);
        end
        checks++;
        if (mon_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL norel_model_count: got %0d want %0d", mon_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (mon_wr[i] !== exp_wr[i]) begin
                    failures++; $display("FAIL norel_wr[%0d]: got %h want %h", i, mon_wr[i], exp_wr[i]);
                end
            end
        end
        checks++;
        if (mon_fd.size() != exp_fd.size()) begin
            failures++; $display("FAIL norel_fd_count: got %0d want %0d", mon_fd.size(), exp_fd.size());
        end else begin
            foreach (exp_fd[i]) begin
                checks++;
                if (mon_fd[i] !== exp_fd[i]) begin
                    failures++; $display("FAIL norel_fd[%0d]: got %h want %h", i, mon_fd[i], exp_fd[i]);
                end
            end
        end
        $display("test_no_release done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_flush_odd();
        bit ok;
        do_reset();
        send_n(5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flodd_send: got timeout want 5 samples"); end
        pulse_flush();
        checks++;
        if (mon_wr.size() != 6) begin
            failures++; $display("FAIL flodd_wr_count: got %0d want 6", mon_wr.size());
        end else if (mon_wr[5] !== 24'h005_000) begin
            failures++; $display("FAIL flodd_pad: got %h want 005000", mon_wr[5]);
        end
        checks++;
        if (mon_fd.size() != 1) begin
            failures++; $display("FAIL flodd_fd_count: got %0d want 1", mon_fd.size());
        end else if (mon_fd[0] !== {1'b1, 12'd5}) begin
            failures++; $display("FAIL flodd_load: got %h want %h", mon_fd[0], {1'b1, 12'd5});
        end
        checks++;
        if (mon_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL flodd_model_count: got %0d want %0d", mon_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (mon_wr[i] !== exp_wr[i]) begin
                    failures++; $display("FAIL flodd_wr[%0d]: got %h want %h", i, mon_wr[i], exp_wr[i]);
                end
            end
        end
        pulse_flush();
        checks++; if (mon_fd.size() != 1) begin failures++; $display("FAIL flush_idx0_fd: got %0d want 1", mon_fd.size()); end
        checks++; if (wr_bank !== 1'b1) begin failures++; $display("FAIL flush_idx0_bank: got %b want 1", wr_bank); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL flush_idx0_ready: got %b want 1", s_ready); end
        $display("test_flush_odd done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_flush_even();
        bit ok;
        do_reset();
        send_n(4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fleven_send: got timeout want 4 samples"); end
        pulse_flush();
        checks++; if (mon_wr.size() != 4) begin failures++; $display("FAIL fleven_no_pad: got %0d writes want 4", mon_wr.size()); end
        checks++; if (wr_bank !== 1'b1) begin failures++; $display("FAIL fleven_bank: got %b want 1", wr_bank); end
        checks++;
        if (mon_fd.size() != 1) begin
            failures++; $display("FAIL fleven_fd_count: got %0d want 1", mon_fd.size());
        end else if (mon_fd[0] !== {1'b1, 12'd3}) begin
            failures++; $display("FAIL fleven_load: got %h want %h", mon_fd[0], {1'b1, 12'd3});
        end
        checks++;
        if (mon_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL fleven_model_count: got %0d want %0d", mon_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (mon_wr[i] !== exp_wr[i]) begin
                    failures++; $display("FAIL fleven_wr[%0d]: got %h want %h", i, mon_wr[i], exp_wr[i]);
                end
            end
        end
        $display("test_flush_even done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_release_at_close();
        bit ok;
        int sent = 0;
        int cyc  = 0;
        do_reset();
        send_n(FL, ok);
        checks++; if (!ok) begin failures++; $display("FAIL relclose_frame1: got timeout want %0d samples", FL); end
        while (sent < FL && cyc < 60) begin
            if (s_ready) begin
                s_valid = 1'b1;
                s_data  = 12'($urandom);
                sent++;
                if (sent == FL) rd_switch = ~rd_switch;
            end else begin
                s_valid = 1'b0;
            end
            @(posedge clk);
            #1 cyc++;
        end
        s_valid = 1'b0;
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL relclose_fd: got %b want 1", frame_done); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL relclose_gap: got %b want 0", s_ready); end
        @(posedge clk);
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL relclose_ready: got %b want 1", s_ready); end
        send_n(1, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL relclose_resume: got timeout want accepted sample"); end
        checks++;
        if (mon_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL relclose_model_count: got %0d want %0d", mon_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (mon_wr[i] !== exp_wr[i]) begin
                    failures++; $display("FAIL relclose_wr[%0d]: got %h want %h", i, mon_wr[i], exp_wr[i]);
                end
            end
        end
        $display("test_release_at_close done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int n_before;
        do_reset();
        send_n(2, ok);
        pulse_flush();
        send_n(3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_send: got timeout want 3 samples"); end
        rst     = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (wea !== 1'b0) begin failures++; $display("FAIL midrst_wea: got %b want 0", wea); end
        checks++; if (addr_w !== 12'h000) begin failures++; $display("FAIL midrst_addr: got %h want 000", addr_w); end
        checks++; if (dina !== 12'h000) begin failures++; $display("FAIL midrst_dina: got %h want 000", dina); end
        checks++; if (load !== 12'h000) begin failures++; $display("FAIL midrst_load: got %h want 000", load); end
        checks++; if (wr_bank !== 1'b0) begin failures++; $display("FAIL midrst_bank: got %b want 0", wr_bank); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b want 0", s_ready); end
        rst = 1'b0;
        n_before = mon_wr.size();
        send_n(1, ok);
        repeat (FL + 3) @(posedge clk);
        #1;
        checks++; if (mon_fd.size() != 1) begin failures++; $display("FAIL midrst_no_fd: got %0d frames want 1", mon_fd.size()); end
        checks++;
        if (mon_wr.size() != n_before + 1) begin
            failures++; $display("FAIL midrst_wr_count: got %0d want %0d", mon_wr.size(), n_before + 1);
        end else if (mon_wr[n_before][23:12] !== 12'h000) begin
            failures++; $display("FAIL midrst_addr0: got %h want 000", mon_wr[n_before][23:12]);
        end
        checks++;
        if (mon_wr.size() != exp_wr.size()) begin
            failures++; $display("FAIL midrst_model_count: got %0d want %0d", mon_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (mon_wr[i] !== exp_wr[i]) begin
                    failures++; $display("FAIL midrst_wr[%0d]: got %h want %h", i, mon_wr[i], exp_wr[i]);
                end
            end
        end
        $display("test_reset_mid_frame done: checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst       = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        flush     = 1'b0;
        rd_switch = 1'b0;
        test_reset();
        test_continuous();
        test_no_release();
        test_flush_odd();
        test_flush_even();
        test_release_at_close();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pingpong_sample_writer.md
Name: pingpong_sample_writer

Overview:
- Write side of the ping-pong ECG sample buffer. It accepts a stream of ADC samples and writes them into one half (bank) of a dual-port BRAM.
- When a frame completes, it publishes the frame length (`load`), hands the filled bank to the pair-reading address counter and starts filling the other bank.
- It stalls the input stream until the reader has released the target bank. The reader's `switch` toggle is the release signal.

Parameters:
- DATA_W, 12, sample width (ADC resolution).
- ADDR_W, 12, BRAM write-address width. MSB is the bank select; the low ADDR_W-1 bits are the in-bank index.
- FRAME_LEN, 2048, samples per full frame. Must be even and satisfy 2 <= FRAME_LEN <= 2^(ADDR_W-1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  writer can accept; transfer occurs when s_valid && s_ready.
- flush  in  1  single-cycle request to close a partial frame.
- rd_switch  in  1  reader bank toggle; any level change means the reader has released its bank.
- wea  out  1  BRAM write enable (registered).
- addr_w  out  ADDR_W  BRAM write address = {bank, idx}.
- dina  out  DATA_W  BRAM write data.
- load  out  ADDR_W  last valid index of the most recently completed frame (sample count - 1).
- frame_done  out  1  one-cycle pulse when a frame is handed over.
- wr_bank  out  1  bank currently being filled.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: wea=0, addr_w=0, dina=0, load=0, frame_done=0, wr_bank=0, s_ready=0.
  - Internal: idx=0, full[1:0]=2'b00, state=FILL, rd_switch_q sampled from rd_switch.
  - Reset mid-frame discards the partial frame; no frame_done is emitted.
- States: FILL, PAD, WAIT_REL.
- s_ready is registered and equals (state==FILL && !rst); it is deasserted in the cycle after a frame closes.
- Release detection: rel = (rd_switch != rd_switch_q). On rel, clear full[~wr_bank], i.e. the bank the reader owned.
- FILL, on transfer:
  - Next cycle: wea=1, addr_w={wr_bank, idx}, dina=s_data. Write latency is 1 cycle.
  - Then idx++.
  - If the accepted sample has idx == FRAME_LEN-1, the frame closes with count FRAME_LEN.
- FILL, flush=1 with no transfer in the same cycle:
  - idx==0: ignored.
  - idx odd: go to PAD.
  - idx even: close the frame with count idx.
- FILL, flush and transfer in the same cycle: the sample is written first, then flush is evaluated on the updated idx.
- PAD: write one zero sample at {wr_bank, idx}, so the reader's address pairs are always complete. Then close the frame with count idx+1.
- Frame close:
  - load <= count-1, frame_done pulses 1 cycle, full[wr_bank] <= 1, wr_bank toggles, idx <= 0.
  - If full[new wr_bank]==1 after applying this cycle's rel, go to WAIT_REL. Otherwise return to FILL.
  - rel and close in the same cycle: the release is applied first.
- WAIT_REL: s_ready=0, wea=0. Leave to FILL in the cycle rel clears full[wr_bank]. flush is ignored.
- wea is 0 in every cycle without a write.
- addr_w and dina hold their last values when wea=0.
- load holds its value until the next close.
- Arithmetic: idx is ADDR_W-1 bits and never exceeds FRAME_LEN-1. No wrap occurs inside a frame.

Decomposition:
- Shared package ecg_buf_pkg:
  - DATA_W, ADDR_W and FRAME_LEN defaults.
  - State enum {FILL, PAD, WAIT_REL}.
  - Bank-select bit position constant. The reader uses the same constant.
- No sub-module is required. The release edge detector may optionally be split out as toggle_edge_det (1 flop + XOR).

Test Plan:
- Continuous valid stream, FRAME_LEN=8, rd_switch toggled 2 cycles after each frame_done:
  - addr_w runs 0..7, then 0x800..0x807.
  - load=7 and frame_done pulses after samples 8 and 16.
  - s_ready is never low for more than 1 cycle.
- Reader never toggles:
  - Frame 1 fills bank 0, frame 2 fills bank 1, then state=WAIT_REL with s_ready=0 and no writes.
  - Toggling rd_switch resumes writes at 0x000.
- Flush after 5 samples:
  - A zero is written at index 5, then load=5 and frame_done fires.
  - Flush with idx=0: no frame_done, state unchanged.
- Flush after 4 samples: load=3, no pad write, wr_bank toggles.
- Release arrives in the same cycle as a frame close with full[other]=1: no WAIT_REL entry; s_ready returns high next cycle.
- rst asserted mid-frame at idx=3:
  - All outputs return to reset values.
  - The next sample is written at address 0, and no frame_done is produced for the partial frame.
